// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller: slot count, field widths,
// scan FSM state encoding and the shadow/entry record layout.
package display_scan_ctrl_pkg;

  localparam int unsigned DISP_NUM_ENTRIES = 44;
  localparam int unsigned NUM_W            = 6;
  localparam int unsigned NAME_W           = 40;
  localparam int unsigned VALUE_W          = 32;
  localparam int unsigned ENTRY_W          = 1 + NAME_W + VALUE_W;

  typedef enum logic [2:0] {
    ST_SET     = 3'd0,
    ST_WAIT    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_CMP     = 3'd3,
    ST_PUSH    = 3'd4,
    ST_NEXT    = 3'd5,
    ST_GAP     = 3'd6
  } scan_state_e;

  // One slot record as held in the shadow table; name/value are zero when !valid.
  typedef struct packed {
    logic               valid;
    logic [NAME_W-1:0]  name;
    logic [VALUE_W-1:0] value;
  } shadow_entry_t;

  // Blank records carry zero payload, so payload only matters when valid.
  function automatic logic entry_differs(shadow_entry_t a, shadow_entry_t b);
    return (a.valid != b.valid) ||
           (a.valid && ((a.name != b.name) || (a.value != b.value)));
  endfunction

endpackage

// File: rtl/display_shadow_ram.sv
// Shadow table of the last record pushed downstream for every slot.
// Ports:
//   clk, reset       - clock, synchronous active-high reset (clears valid bits)
//   rd_addr/rd_data  - combinational read port, {valid, name, value}
//   wr_en/wr_addr/wr_data - synchronous write port
module display_shadow_ram
  import display_scan_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = DISP_NUM_ENTRIES,
  parameter int unsigned ADDR_W = NUM_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data
);

  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   valid_d;
  logic [ENTRY_W-2:0] payload_q [DEPTH];

  // Valid bits are resettable; the payload array is not.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_addr] = wr_data[ENTRY_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      payload_q[wr_addr] <= wr_data[ENTRY_W-2:0];
    end
  end

  assign rd_data = {valid_q[rd_addr], payload_q[rd_addr]};

endmodule

// File: rtl/display_scan_ctrl.sv
// Display scan controller: walks slots 1..NUM_ENTRIES, queries the display
// source, compares each answer with a shadow table and offers changed (or, in
// a full-push frame, all) records downstream with valid/ready. A keypad commit
// path runs alongside, independent of the scan.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   display_number (out)             - slot being queried
//   display_valid/name/value (in)    - source answer, stable RESP_LAT cycles later
//   ent_valid/ready/number/blank/name/value - downstream record handshake
//   refresh_req, key_valid (in)      - request a full push next frame
//   key_value (in), input_valid/input_value (out) - keypad commit path
//   frame_done (out)                 - one-cycle pulse at the end of each frame
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = DISP_NUM_ENTRIES,
  parameter int unsigned RESP_LAT    = 2,
  parameter int unsigned FRAME_GAP   = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [5:0]  display_number,
  input  logic        display_valid,
  input  logic [39:0] display_name,
  input  logic [31:0] display_value,
  output logic        ent_valid,
  input  logic        ent_ready,
  output logic [5:0]  ent_number,
  output logic        ent_blank,
  output logic [39:0] ent_name,
  output logic [31:0] ent_value,
  input  logic        refresh_req,
  input  logic        key_valid,
  input  logic [31:0] key_value,
  output logic        input_valid,
  output logic [31:0] input_value,
  output logic        frame_done
);

  // SET plus WAIT together cover the RESP_LAT-cycle response window, so the
  // CAPTURE edge lands RESP_LAT+1 edges after display_number changes.
  localparam int unsigned WAIT_LAST = (RESP_LAT > 1) ? RESP_LAT - 2 : 0;
  localparam int unsigned WAIT_W    = (RESP_LAT > 1) ? $clog2(RESP_LAT + 1) : 1;
  // GAP always lasts at least one cycle.
  localparam int unsigned GAP_LAST  = (FRAME_GAP > 1) ? FRAME_GAP - 1 : 0;
  localparam int unsigned GAP_W     = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  scan_state_e          state_q, state_d;
  logic [NUM_W-1:0]     slot_q, slot_d;
  logic [NUM_W-1:0]     display_number_q, display_number_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  shadow_entry_t        cap_q, cap_d;
  logic                 full_q, full_d;
  logic                 pending_q, pending_d;
  logic                 ent_valid_q, ent_valid_d;
  logic [NUM_W-1:0]     ent_number_q, ent_number_d;
  logic                 ent_blank_q, ent_blank_d;
  logic [NAME_W-1:0]    ent_name_q, ent_name_d;
  logic [VALUE_W-1:0]   ent_value_q, ent_value_d;
  logic                 frame_done_q, frame_done_d;
  logic                 input_valid_q, input_valid_d;
  logic [VALUE_W-1:0]   input_value_q, input_value_d;

  logic                 shadow_we;
  logic [NUM_W-1:0]     shadow_rd_addr;
  logic [NUM_W-1:0]     shadow_wr_addr;
  logic [ENTRY_W-1:0]   shadow_rd_raw;
  logic [ENTRY_W-1:0]   shadow_wr_data;
  shadow_entry_t        shadow_rd;

  // Shadow is indexed by slot-1; it is written on the accepting PUSH edge.
  assign shadow_rd_addr = NUM_W'(slot_q - 1'b1);
  assign shadow_wr_addr = NUM_W'(ent_number_q - 1'b1);
  assign shadow_we      = (state_q == ST_PUSH) && ent_ready && !reset;
  assign shadow_wr_data = {!ent_blank_q, ent_name_q, ent_value_q};
  assign shadow_rd      = shadow_entry_t'(shadow_rd_raw);

  display_shadow_ram #(
    .DEPTH  (NUM_ENTRIES),
    .ADDR_W (NUM_W)
  ) u_shadow (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (shadow_rd_addr),
    .rd_data (shadow_rd_raw),
    .wr_en   (shadow_we),
    .wr_addr (shadow_wr_addr),
    .wr_data (shadow_wr_data)
  );

  // Next-state and output logic for the scan FSM and the keypad path.
  always_comb begin
    state_d          = state_q;
    slot_d           = slot_q;
    display_number_d = display_number_q;
    wait_cnt_d       = wait_cnt_q;
    gap_cnt_d        = gap_cnt_q;
    cap_d            = cap_q;
    full_d           = full_q;
    ent_valid_d      = ent_valid_q;
    ent_number_d     = ent_number_q;
    ent_blank_d      = ent_blank_q;
    ent_name_d       = ent_name_q;
    ent_value_d      = ent_value_q;
    frame_done_d     = 1'b0;

    // Full-push requests accumulate here and are promoted at frame start.
    pending_d        = pending_q | refresh_req | key_valid;

    input_valid_d    = key_valid;
    input_value_d    = key_valid ? key_value : input_value_q;

    unique case (state_q)
      ST_SET: begin
        if (RESP_LAT > 1) begin
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end else begin
          state_d    = ST_CAPTURE;
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == WAIT_W'(WAIT_LAST)) begin
          state_d = ST_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_CAPTURE: begin
        cap_d.valid = display_valid;
        cap_d.name  = display_valid ? display_name  : '0;
        cap_d.value = display_valid ? display_value : '0;
        state_d     = ST_CMP;
      end

      ST_CMP: begin
        if (full_q || entry_differs(cap_q, shadow_rd)) begin
          ent_valid_d  = 1'b1;
          ent_number_d = slot_q;
          ent_blank_d  = !cap_q.valid;
          ent_name_d   = cap_q.name;
          ent_value_d  = cap_q.value;
          state_d      = ST_PUSH;
        end else begin
          state_d      = ST_NEXT;
        end
      end

      ST_PUSH: begin
        if (ent_ready) begin
          ent_valid_d = 1'b0;
          state_d     = ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (slot_q == NUM_W'(NUM_ENTRIES)) begin
          // display_number stays put until GAP ends so slot 1 sees a fresh change.
          slot_d       = NUM_W'(1);
          frame_done_d = 1'b1;
          full_d       = 1'b0;
          gap_cnt_d    = '0;
          state_d      = ST_GAP;
        end else begin
          slot_d           = slot_q + 1'b1;
          display_number_d = slot_q + 1'b1;
          state_d          = ST_SET;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          display_number_d = slot_q;
          full_d           = pending_d;
          pending_d        = 1'b0;
          state_d          = ST_SET;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_SET;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_SET;
      slot_q           <= NUM_W'(1);
      display_number_q <= NUM_W'(1);
      wait_cnt_q       <= '0;
      gap_cnt_q        <= '0;
      cap_q            <= '0;
      full_q           <= 1'b1;
      pending_q        <= 1'b0;
      ent_valid_q      <= 1'b0;
      ent_number_q     <= '0;
      ent_blank_q      <= 1'b0;
      ent_name_q       <= '0;
      ent_value_q      <= '0;
      frame_done_q     <= 1'b0;
      input_valid_q    <= 1'b0;
      input_value_q    <= '0;
    end else begin
      state_q          <= state_d;
      slot_q           <= slot_d;
      display_number_q <= display_number_d;
      wait_cnt_q       <= wait_cnt_d;
      gap_cnt_q        <= gap_cnt_d;
      cap_q            <= cap_d;
      full_q           <= full_d;
      pending_q        <= pending_d;
      ent_valid_q      <= ent_valid_d;
      ent_number_q     <= ent_number_d;
      ent_blank_q      <= ent_blank_d;
      ent_name_q       <= ent_name_d;
      ent_value_q      <= ent_value_d;
      frame_done_q     <= frame_done_d;
      input_valid_q    <= input_valid_d;
      input_value_q    <= input_value_d;
    end
  end

  assign display_number = display_number_q;
  assign ent_valid      = ent_valid_q;
  assign ent_number     = ent_number_q;
  assign ent_blank      = ent_blank_q;
  assign ent_name       = ent_name_q;
  assign ent_value      = ent_value_q;
  assign frame_done     = frame_done_q;
  assign input_valid    = input_valid_q;
  assign input_value    = input_value_q;

endmodule
